// File: rtl/stoch_pkg.sv
// Shared types and defaults for the stochastic number generator slice.
// Feedback masks are right-shift Galois form, maximal-length for their width.
package stoch_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [3:0]  POLY_W4      = 4'hC;
    localparam logic [7:0]  POLY_W8      = 8'hB8;
    localparam logic [15:0] POLY_W16     = 16'hB400;
    localparam int          SEED_DEFAULT = 1;

    // Unsupported widths fall back to the 8-bit mask; callers must then override POLY.
    function automatic logic [15:0] default_poly(input int width);
        case (width)
            4:       default_poly = {12'h000, POLY_W4};
            16:      default_poly = POLY_W16;
            default: default_poly = {8'h00, POLY_W8};
        endcase
    endfunction

endpackage

// File: rtl/stoch_bitstream_gen_if.sv
// Controller-facing handshake and stream bus of the stochastic number generator.
interface stoch_bitstream_gen_if #(
    parameter int WIDTH     = 8,
    parameter int LEN_WIDTH = 16
);

    logic                 start;
    logic [WIDTH-1:0]     value;
    logic [LEN_WIDTH-1:0] length;
    logic                 abort;
    logic                 seed_load;
    logic [WIDTH-1:0]     seed;
    logic                 ready;
    logic                 out_bit;
    logic                 out_valid;
    logic                 done;

    modport master (
        output start, value, length, abort, seed_load, seed,
        input  ready, out_bit, out_valid, done
    );

    modport slave (
        input  start, value, length, abort, seed_load, seed,
        output ready, out_bit, out_valid, done
    );

endinterface

// File: rtl/stoch_lfsr.sv
// Galois LFSR with optional load; a zero load value is forced to 1 so the
// register can never lock up in the all-zero state.
module stoch_lfsr #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = 8'hB8,
    parameter logic [WIDTH-1:0] SEED  = 8'h01
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] state
);

    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] next;

    // Load happens before the step so a load+step cycle advances from the new seed.
    always_comb begin
        base = state;
        if (load) begin
            base = (load_val == '0) ? WIDTH'(1) : load_val;
        end
        next = base;
        if (step) begin
            next = {1'b0, base[WIDTH-1:1]} ^ (base[0] ? POLY : '0);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= SEED;
        end else begin
            state <= next;
        end
    end

endmodule

// File: rtl/stoch_bitstream_gen.sv
// Stochastic number generator: emits `length` unipolar bits, one per clock,
// each bit being (lfsr <= value) for the held probability word.
module stoch_bitstream_gen
    import stoch_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               LEN_WIDTH = 16,
    parameter logic [WIDTH-1:0] POLY      = WIDTH'(default_poly(WIDTH)),
    parameter logic [WIDTH-1:0] SEED      = WIDTH'(SEED_DEFAULT)
) (
    input logic                  CLK,
    input logic                  nRST,
    stoch_bitstream_gen_if.slave bus
);

    state_t               state;
    state_t               next_state;
    logic [WIDTH-1:0]     value_q;
    logic [LEN_WIDTH-1:0] count;
    logic                 out_bit_q;
    logic                 out_valid_q;
    logic                 done_q;

    logic [WIDTH-1:0]     nxt_value;
    logic [LEN_WIDTH-1:0] nxt_count;
    logic                 nxt_bit;
    logic                 nxt_valid;
    logic                 nxt_done;

    logic                 step;
    logic                 load;
    logic                 accept;
    logic [WIDTH-1:0]     lfsr_state;
    logic [WIDTH-1:0]     lfsr_src;

    // count holds the bits still to emit after the one currently on out_bit.
    assign load     = (state == IDLE) && bus.seed_load;
    assign accept   = (state == IDLE) && bus.start && (bus.length != '0);
    assign lfsr_src = load ? ((bus.seed == '0) ? WIDTH'(1) : bus.seed) : lfsr_state;

    stoch_lfsr #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_lfsr (
        .CLK      (CLK),
        .nRST     (nRST),
        .step     (step),
        .load     (load),
        .load_val (bus.seed),
        .state    (lfsr_state)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = RUN;
            RUN:     if (bus.abort || count == '0) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The first bit is emitted on the accepting edge, so RUN spans exactly the valid cycles.
    always_comb begin
        step      = 1'b0;
        nxt_valid = 1'b0;
        nxt_bit   = 1'b0;
        nxt_done  = 1'b0;
        nxt_count = count;
        nxt_value = value_q;
        case (state)
            IDLE: begin
                if (bus.start && bus.length == '0) begin
                    nxt_done = 1'b1;
                end else if (accept) begin
                    step      = 1'b1;
                    nxt_valid = 1'b1;
                    nxt_bit   = (lfsr_src <= bus.value);
                    nxt_value = bus.value;
                    nxt_count = bus.length - LEN_WIDTH'(1);
                    nxt_done  = (bus.length == LEN_WIDTH'(1));
                end
            end
            RUN: begin
                if (bus.abort && count != '0) begin
                    nxt_done  = 1'b1;
                    nxt_count = '0;
                end else if (count != '0) begin
                    step      = 1'b1;
                    nxt_valid = 1'b1;
                    nxt_bit   = (lfsr_state <= value_q);
                    nxt_count = count - LEN_WIDTH'(1);
                    nxt_done  = (count == LEN_WIDTH'(1));
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            value_q     <= '0;
            count       <= '0;
            out_bit_q   <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            value_q     <= nxt_value;
            count       <= nxt_count;
            out_bit_q   <= nxt_bit;
            out_valid_q <= nxt_valid;
            done_q      <= nxt_done;
        end
    end

    assign bus.ready     = (state == IDLE);
    assign bus.out_bit   = out_bit_q;
    assign bus.out_valid = out_valid_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_stoch_bitstream_gen.sv
// Scoreboard bench for stoch_bitstream_gen: a reference Galois LFSR predicts
// every stream bit, and run framing (ready/done/abort/reset) is checked per run.
module tb_stoch_bitstream_gen;

    logic CLK = 1'b0;
    logic nRST;

    stoch_bitstream_gen_if #(.WIDTH(8), .LEN_WIDTH(16)) bus ();

    stoch_bitstream_gen #(
        .WIDTH     (8),
        .LEN_WIDTH (16),
        .POLY      (8'hB8),
        .SEED      (8'h01)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    int         checks = 0;
    int         errors = 0;
    logic       exp_q[$];
    logic [7:0] model;
    int         valid_cnt;
    int         ones_cnt;
    int         valid_at_done;
    logic       done_seen;
    logic       done_with_valid;

    function automatic logic [7:0] galois(input logic [7:0] x);
        return {1'b0, x[7:1]} ^ (x[0] ? 8'hB8 : 8'h00);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Pushes the predicted bits, launches a run, then samples every cycle until done.
    task automatic applyStimulus(input logic [7:0] val, input int len, input bit do_seed,
                                 input logic [7:0] sd, input int abort_after, input int disturb_at);
        int n_emit;
        int exp_ones;
        int cyc;
        if (do_seed) model = (sd == 8'h00) ? 8'h01 : sd;
        n_emit   = (abort_after > 0 && abort_after < len) ? abort_after : len;
        exp_ones = 0;
        for (int i = 0; i < n_emit; i++) begin
            exp_q.push_back(model <= val);
            if (model <= val) exp_ones++;
            model = galois(model);
        end
        valid_cnt       = 0;
        ones_cnt        = 0;
        valid_at_done   = 0;
        done_seen       = 1'b0;
        done_with_valid = 1'b0;

        @(negedge CLK);
        bus.start     = 1'b1;
        bus.value     = val;
        bus.length    = 16'(len);
        bus.seed_load = do_seed;
        bus.seed      = sd;
        cyc = 0;
        while (!done_seen && cyc < len + 8) begin
            @(negedge CLK);
            cyc++;
            bus.start     = 1'b0;
            bus.seed_load = 1'b0;
            bus.abort     = 1'b0;
            checkOutput("ready_vs_valid", 32'(bus.ready), 32'(!bus.out_valid));
            if (bus.out_valid) begin
                valid_cnt++;
                ones_cnt += int'(bus.out_bit);
                if (exp_q.size() == 0) checkOutput("extra_bit", 1, 0);
                else checkOutput($sformatf("bit%0d", valid_cnt), 32'(bus.out_bit), 32'(exp_q.pop_front()));
            end
            if (bus.done) begin
                done_seen       = 1'b1;
                done_with_valid = bus.out_valid;
                valid_at_done   = valid_cnt;
            end else begin
                if (abort_after > 0 && valid_cnt == abort_after && bus.out_valid) bus.abort = 1'b1;
                if (disturb_at > 0 && valid_cnt == disturb_at) begin
                    bus.start     = 1'b1;
                    bus.value     = 8'd10;
                    bus.length    = 16'd20;
                    bus.seed_load = 1'b1;
                    bus.seed      = 8'h55;
                end
            end
        end
        checkOutput("done_seen", 32'(done_seen), 1);
        checkOutput("valid_count", valid_cnt, n_emit);
        checkOutput("ones_count", ones_cnt, exp_ones);
        checkOutput("done_with_valid", 32'(done_with_valid), 32'(n_emit == len && len > 0));
        checkOutput("bits_before_done", valid_at_done, n_emit);
        checkOutput("queue_empty", exp_q.size(), 0);
        @(negedge CLK);
        checkOutput("ready_after", 32'(bus.ready), 1);
        checkOutput("done_pulse_width", 32'(bus.done), 0);
        checkOutput("valid_after", 32'(bus.out_valid), 0);
        exp_q.delete();
    endtask

    initial begin
        nRST          = 1'b0;
        bus.start     = 1'b0;
        bus.value     = 8'h00;
        bus.length    = 16'h0000;
        bus.abort     = 1'b0;
        bus.seed_load = 1'b0;
        bus.seed      = 8'h00;
        model         = 8'h01;
        #23 nRST = 1'b1;
        @(negedge CLK);
        checkOutput("rst_ready", 32'(bus.ready), 1);
        checkOutput("rst_valid", 32'(bus.out_valid), 0);
        checkOutput("rst_done", 32'(bus.done), 0);
        checkOutput("rst_bit", 32'(bus.out_bit), 0);

        // Full LFSR period: ones count equals the value word exactly.
        applyStimulus(8'd100, 255, 1'b1, 8'h01, 0, 0);
        checkOutput("period_ones_100", ones_cnt, 100);
        applyStimulus(8'd0, 255, 1'b0, 8'h00, 0, 0);
        checkOutput("period_ones_0", ones_cnt, 0);
        applyStimulus(8'd255, 255, 1'b0, 8'h00, 0, 0);
        checkOutput("period_ones_255", ones_cnt, 255);

        applyStimulus(8'd50, 0, 1'b0, 8'h00, 0, 0);
        applyStimulus(8'd200, 50, 1'b0, 8'h00, 0, 10);
        applyStimulus(8'd128, 40, 1'b0, 8'h00, 7, 0);
        applyStimulus(8'd128, 20, 1'b0, 8'h00, 0, 0);
        applyStimulus(8'd90, 30, 1'b1, 8'h00, 0, 0);
        applyStimulus(8'd77, 1, 1'b0, 8'h00, 0, 0);

        @(negedge CLK);
        bus.seed_load = 1'b1;
        bus.seed      = 8'hA5;
        @(negedge CLK);
        bus.seed_load = 1'b0;
        model = 8'hA5;
        applyStimulus(8'd128, 16, 1'b0, 8'h00, 0, 0);

        // Asynchronous reset in the middle of a run.
        @(negedge CLK);
        bus.start  = 1'b1;
        bus.value  = 8'd128;
        bus.length = 16'd40;
        @(negedge CLK);
        bus.start = 1'b0;
        checkOutput("midrst_running", 32'(bus.out_valid), 1);
        repeat (4) @(negedge CLK);
        #2 nRST = 1'b0;
        #1;
        checkOutput("midrst_ready", 32'(bus.ready), 1);
        checkOutput("midrst_valid", 32'(bus.out_valid), 0);
        checkOutput("midrst_done", 32'(bus.done), 0);
        checkOutput("midrst_bit", 32'(bus.out_bit), 0);
        done_seen = 1'b0;
        repeat (2) begin
            @(negedge CLK);
            if (bus.done) done_seen = 1'b1;
        end
        #2 nRST = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            if (bus.done || bus.out_valid) done_seen = 1'b1;
        end
        checkOutput("midrst_no_done", 32'(done_seen), 0);
        model = 8'h01;
        applyStimulus(8'd128, 12, 1'b0, 8'h00, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stoch_bitstream_gen.md
Name: stoch_bitstream_gen

Overview:
Stochastic number generator (SNG). Converts a binary probability word into a unipolar stochastic bitstream of programmable length, one bit per clock.
- Bits are produced by comparing a maximal-length Galois LFSR against the held value.
- Sits directly upstream of the stochastic monitor/counter and the stochastic arithmetic stages.
- A start/ready handshake and a done pulse let a controller frame each run.

Parameters:
WIDTH, 8, bit width of value, seed and LFSR
LEN_WIDTH, 16, bit width of the stream-length field
POLY, 8'hB8, Galois feedback mask (right-shift form); must be maximal-length for WIDTH
SEED, 1, LFSR reset value; must be nonzero

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
start  in  1  request a run; accepted only when ready=1
value  in  WIDTH  probability word, P(1) = value/(2^WIDTH-1); sampled on accept
length  in  LEN_WIDTH  number of bits to emit; sampled on accept
abort  in  1  terminate the current run
seed_load  in  1  load seed into LFSR; honoured only in IDLE
seed  in  WIDTH  new LFSR state
ready  out  1  high in IDLE
out_bit  out  1  stochastic bit
out_valid  out  1  out_bit is a stream bit this cycle
done  out  1  one-cycle pulse marking end of run

Behaviour:
- Reset (async, nRST=0):
  - state=IDLE, lfsr=SEED, value_q=0, count=0.
  - ready=1, out_bit=0, out_valid=0, done=0.
- All outputs are registered. ready is decoded from the state register.
- IDLE:
  - ready=1, out_valid=0, out_bit=0.
  - start=1 with length!=0: latch value_q and count=length, go to RUN.
  - start=1 with length=0: done=1 next cycle, no valid bits, stay IDLE.
  - seed_load=1 (no start): lfsr=seed; seed=0 loads 1 to avoid lock-up.
  - start and seed_load in the same cycle: seed load first, then the run begins from the new seed.
- RUN:
  - ready=0. Each cycle out_valid=1 and out_bit = (lfsr <= value_q), registered.
  - lfsr advances one Galois step per emitted bit: lsb=lfsr[0]; lfsr = (lfsr>>1) ^ (lsb ? POLY : 0).
  - count decrements per emitted bit.
  - The cycle emitting the final bit also asserts done=1; the FSM then returns to IDLE (ready=1 the following cycle).
  - start and seed_load are ignored in RUN.
- Latency:
  - First valid bit appears the cycle after start is accepted.
  - Exactly `length` consecutive out_valid cycles; no bubbles.
- Abort:
  - abort=1 in RUN: next cycle out_valid=0, done=1, state=IDLE.
  - abort takes priority over the final-bit case.
  - abort in IDLE has no effect.
- Value boundaries:
  - value=0 gives all zeros (lfsr is never 0).
  - value=2^WIDTH-1 gives all ones.
  - Over any 2^WIDTH-1 consecutive bits, the number of ones equals value exactly.
- LFSR state persists across runs; it is not reseeded per run unless seed_load is used.
- Counter width: count is LEN_WIDTH bits; length=2^LEN_WIDTH-1 is legal, with no wrap.
- Reset mid-run: immediate return to the reset values; any partial stream is discarded and no done is emitted.

Decomposition:
- Package stoch_pkg:
  - state enum {IDLE, RUN}
  - default POLY constants per WIDTH (4: 4'hC, 8: 8'hB8, 16: 16'hB400)
  - SEED default
- Sub-module stoch_lfsr (WIDTH, POLY, SEED):
  - inputs: CLK, nRST, step, load, load_val
  - output: state
  - contains the zero-seed guard
- Top-level module holds the FSM, length counter and comparator.

Test Plan:
- Reset release → ready=1, out_valid=0, done=0, out_bit=0. Assert nRST low asynchronously between clock edges → outputs clear without a clock.
- Full-period count: seed_load seed=8'h01; then start, value=100, length=255 → exactly 255 valid cycles starting the cycle after accept; ones count=100; done coincides with the 255th bit; ready=1 the next cycle. Repeat with value=0 (0 ones) and value=255 (255 ones).
- length=0 start → done pulses once, out_valid never asserts, ready stays 1.
- Start pulsed again during RUN (value=10, length=20) → ignored; the original run (value=200, length=50) completes with 50 bits; seed_load during RUN has no effect on the sequence.
- Abort after 7 bits of a length=40 run → 7 valid bits, then done=1 with out_valid=0, IDLE; the next run's LFSR continues from the advanced state, matching the golden sequence.
- seed_load seed=0 in IDLE → LFSR holds 1; the following stream matches a seed=1 golden model. nRST mid-run → lfsr=SEED, ready=1, no done.
